gray_ptr_ctl: RTL and testbench

- Parametrised Gray-code pointer controller: one side (write or read) of an asynchronous FIFO in the SDRAM controller's clock-crossing paths.
- Holds a local binary/Gray pointer pair that advances on request.
- Synchronises the other domain's Gray pointer into this domain and converts it to binary.
- Produces a registered full flag (write side) or empty flag (read side) and an occupancy level.

---
 rtl/gray_pkg.sv | 23 ++
 rtl/gray_sync.sv | 29 ++
 rtl/gray_ptr_ctl.sv | 77 +++++++
 tb/tb_gray_ptr_ctl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Gray/binary conversion helpers and side selectors for async FIFO pointers
package gray_pkg;

    localparam int SIDE_WR = 0;
    localparam int SIDE_RD = 1;

    // Functions work on a fixed wide vector; callers zero-extend and size-cast to AW+1.
    localparam int GW = 32;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] gray);
        logic [GW-1:0] bin;
        bin[GW-1] = gray[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-stage flop chain bringing a remote Gray pointer into the local clock
module gray_sync #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_ctl.sv
// rtl/gray_ptr_ctl.sv - one side of an async FIFO: local Gray pointer, remote sync, full/empty and level
module gray_ptr_ctl
    import gray_pkg::*;
#(
    parameter int AW          = 9,
    parameter int SIDE        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLKGR,
    input  logic          RSTGR,
    input  logic          inc,
    input  logic [AW:0]   remote_gray,
    output logic [AW:0]   ptr_bin,
    output logic [AW:0]   ptr_gray,
    output logic [AW-1:0] addr,
    output logic          flag,
    output logic [AW:0]   level
);

    localparam int PW = AW + 1;

    logic [AW:0] bin_q, bin_d;
    logic [AW:0] gray_q, gray_d;
    logic [AW:0] level_q, level_d;
    logic        flag_q, flag_d;
    logic        accept;
    logic [AW:0] rgray_s;
    logic [AW:0] rbin;

    gray_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (CLKGR),
        .rst_i (RSTGR),
        .d_i   (remote_gray),
        .q_o   (rgray_s)
    );

    // Flag and level use next-state pointers so a local accept is reflected on the same edge.
    always_comb begin
        accept  = inc & ~flag_q;
        bin_d   = bin_q + {{AW{1'b0}}, accept};
        gray_d  = PW'(bin2gray(GW'(bin_d)));
        rbin    = PW'(gray2bin(GW'(rgray_s)));
        flag_d  = 1'b0;
        level_d = '0;
        if (SIDE == SIDE_WR) begin
            flag_d  = (gray_d == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
            level_d = bin_d - rbin;
        end else begin
            flag_d  = (gray_d == rgray_s);
            level_d = rbin - bin_d;
        end
    end

    always_ff @(posedge CLKGR) begin
        if (RSTGR) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            flag_q  <= (SIDE == SIDE_RD);
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            flag_q  <= flag_d;
        end
    end

    assign ptr_bin  = bin_q;
    assign ptr_gray = gray_q;
    assign addr     = bin_q[AW-1:0];
    assign flag     = flag_q;
    assign level    = level_q;

endmodule

// File: tb/tb_gray_ptr_ctl.sv
// tb/tb_gray_ptr_ctl.sv - scoreboard bench for write-side and read-side pointer controllers
module tb_gray_ptr_ctl;

    logic       clk = 1'b0;
    logic       rst_v [2];
    logic       inc_v [2];
    logic [3:0] rem_v [2];

    logic [3:0] wr_bin, wr_gray, wr_level, rd_bin, rd_gray, rd_level;
    logic [2:0] wr_addr, rd_addr;
    logic       wr_flag, rd_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         side;
        logic [3:0] bin;
        logic [3:0] gray;
        logic [3:0] level;
        logic       flag;
    } exp_t;

    exp_t sb_q[$];

    logic [3:0] m_bin [2];
    logic [3:0] m_s0 [2];
    logic [3:0] m_s1 [2];
    logic [3:0] m_level [2];
    logic       m_flag [2];

    always #5 clk = ~clk;

    gray_ptr_ctl #(.AW(3), .SIDE(0), .SYNC_STAGES(2)) dut_wr (
        .CLKGR(clk), .RSTGR(rst_v[0]), .inc(inc_v[0]), .remote_gray(rem_v[0]),
        .ptr_bin(wr_bin), .ptr_gray(wr_gray), .addr(wr_addr), .flag(wr_flag), .level(wr_level)
    );

    gray_ptr_ctl #(.AW(3), .SIDE(1), .SYNC_STAGES(2)) dut_rd (
        .CLKGR(clk), .RSTGR(rst_v[1]), .inc(inc_v[1]), .remote_gray(rem_v[1]),
        .ptr_bin(rd_bin), .ptr_gray(rd_gray), .addr(rd_addr), .flag(rd_flag), .level(rd_level)
    );

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Behavioural model in binary counts: full means 8 outstanding, empty means 0.
    task automatic tick();
        exp_t       e;
        logic [3:0] rb, bn, lv;
        logic       acc;
        for (int s = 0; s < 2; s++) begin
            if (rst_v[s]) begin
                m_bin[s] = 4'd0; m_s0[s] = 4'd0; m_s1[s] = 4'd0;
                m_flag[s] = (s == 1); m_level[s] = 4'd0;
            end else begin
                rb  = g2b(m_s1[s]);
                acc = inc_v[s] && !m_flag[s];
                bn  = m_bin[s] + {3'b000, acc};
                if (s == 0) begin
                    lv = bn - rb;
                    m_flag[s] = (lv == 4'd8);
                end else begin
                    lv = rb - bn;
                    m_flag[s] = (lv == 4'd0);
                end
                m_bin[s] = bn; m_level[s] = lv;
                m_s1[s] = m_s0[s]; m_s0[s] = rem_v[s];
            end
            e.side = s; e.bin = m_bin[s]; e.gray = m_bin[s] ^ (m_bin[s] >> 1);
            e.level = m_level[s]; e.flag = m_flag[s];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    exp_t       me;
    logic [3:0] a_bin, a_gray, a_level;
    logic [2:0] a_addr;
    logic       a_flag;

    always @(posedge clk) begin
        #1;
        while (sb_q.size() > 0) begin
            me      = sb_q.pop_front();
            a_bin   = (me.side == 1) ? rd_bin   : wr_bin;
            a_gray  = (me.side == 1) ? rd_gray  : wr_gray;
            a_level = (me.side == 1) ? rd_level : wr_level;
            a_addr  = (me.side == 1) ? rd_addr  : wr_addr;
            a_flag  = (me.side == 1) ? rd_flag  : wr_flag;
            total += 5;
            if (a_bin !== me.bin) begin bad++; $display("FAIL sb_bin side=%0d got=%h exp=%h", me.side, a_bin, me.bin); end
            if (a_gray !== me.gray) begin bad++; $display("FAIL sb_gray side=%0d got=%h exp=%h", me.side, a_gray, me.gray); end
            if (a_level !== me.level) begin bad++; $display("FAIL sb_level side=%0d got=%h exp=%h", me.side, a_level, me.level); end
            if (a_addr !== me.bin[2:0]) begin bad++; $display("FAIL sb_addr side=%0d got=%h exp=%h", me.side, a_addr, me.bin[2:0]); end
            if (a_flag !== me.flag) begin bad++; $display("FAIL sb_flag side=%0d got=%b exp=%b", me.side, a_flag, me.flag); end
        end
    end

    task automatic test_reset();
        rst_v[0] = 1'b1; rst_v[1] = 1'b1; inc_v[0] = 1'b1; inc_v[1] = 1'b1;
        rem_v[0] = 4'd0; rem_v[1] = 4'd0;
        tick(); tick();
        total += 4;
        if (wr_bin !== 4'd0) begin bad++; $display("FAIL reset_bin got=%h exp=0", wr_bin); end
        if (wr_flag !== 1'b0) begin bad++; $display("FAIL reset_wr_flag got=%b exp=0", wr_flag); end
        if (rd_flag !== 1'b1) begin bad++; $display("FAIL reset_rd_flag got=%b exp=1", rd_flag); end
        if (wr_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%h exp=0", wr_level); end
        rst_v[0] = 1'b0; rst_v[1] = 1'b0; inc_v[0] = 1'b0; inc_v[1] = 1'b0;
    endtask

    task automatic test_fill();
        inc_v[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) begin
                total++;
                if (wr_flag !== 1'b0) begin bad++; $display("FAIL fill_early_full got=%b exp=0", wr_flag); end
            end
        end
        total += 4;
        if (wr_bin !== 4'd8) begin bad++; $display("FAIL fill_bin got=%h exp=8", wr_bin); end
        if (wr_gray !== 4'b1100) begin bad++; $display("FAIL fill_gray got=%b exp=1100", wr_gray); end
        if (wr_level !== 4'd8) begin bad++; $display("FAIL fill_level got=%h exp=8", wr_level); end
        if (wr_flag !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", wr_flag); end
        tick();
        total++;
        if (wr_bin !== 4'd8) begin bad++; $display("FAIL fill_ignored got=%h exp=8", wr_bin); end
        inc_v[0] = 1'b0;
    endtask

    task automatic test_full_release();
        rem_v[0] = 4'b0110;
        tick(); tick();
        total++;
        if (wr_flag !== 1'b1) begin bad++; $display("FAIL release_early got=%b exp=1", wr_flag); end
        tick();
        total += 2;
        if (wr_flag !== 1'b0) begin bad++; $display("FAIL release_flag got=%b exp=0", wr_flag); end
        if (wr_level !== 4'd4) begin bad++; $display("FAIL release_level got=%h exp=4", wr_level); end
        inc_v[0] = 1'b1;
        tick();
        total++;
        if (wr_bin !== 4'd9) begin bad++; $display("FAIL release_accept got=%h exp=9", wr_bin); end
        inc_v[0] = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] prev_gray, prev_bin, tgt;
        int         wraps;
        rst_v[0] = 1'b1; tick(); rst_v[0] = 1'b0;
        wraps = 0;
        inc_v[0] = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tgt = m_bin[0] - 4'd2;
            rem_v[0] = tgt ^ (tgt >> 1);
            prev_gray = wr_gray; prev_bin = wr_bin;
            tick();
            total += 2;
            if ($countones(wr_gray ^ prev_gray) != 1) begin bad++; $display("FAIL wrap_onebit got=%b prev=%b", wr_gray, prev_gray); end
            if (wr_gray !== (wr_bin ^ (wr_bin >> 1))) begin bad++; $display("FAIL wrap_bin2gray got=%b bin=%h", wr_gray, wr_bin); end
            if (prev_bin == 4'd15) begin
                wraps++;
                total++;
                if (wr_bin !== 4'd0 || wr_gray !== 4'b0000 || prev_gray !== 4'b1000) begin
                    bad++; $display("FAIL wrap_step got bin=%h gray=%b prev_gray=%b exp 0/0000/1000", wr_bin, wr_gray, prev_gray);
                end
            end
        end
        total++;
        if (wraps != 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", wraps); end
        inc_v[0] = 1'b0; rem_v[0] = 4'd0;
    endtask

    task automatic test_read_side();
        rst_v[1] = 1'b1; tick(); rst_v[1] = 1'b0;
        total++;
        if (rd_flag !== 1'b1) begin bad++; $display("FAIL rd_reset_empty got=%b exp=1", rd_flag); end
        rem_v[1] = 4'b0011;
        tick(); tick();
        total++;
        if (rd_flag !== 1'b1) begin bad++; $display("FAIL rd_early got=%b exp=1", rd_flag); end
        tick();
        total += 2;
        if (rd_flag !== 1'b0) begin bad++; $display("FAIL rd_flag got=%b exp=0", rd_flag); end
        if (rd_level !== 4'd2) begin bad++; $display("FAIL rd_level got=%h exp=2", rd_level); end
        inc_v[1] = 1'b1;
        tick(); tick();
        total += 3;
        if (rd_flag !== 1'b1) begin bad++; $display("FAIL rd_empty got=%b exp=1", rd_flag); end
        if (rd_level !== 4'd0) begin bad++; $display("FAIL rd_level0 got=%h exp=0", rd_level); end
        if (rd_bin !== 4'd2) begin bad++; $display("FAIL rd_bin got=%h exp=2", rd_bin); end
        tick();
        total++;
        if (rd_bin !== 4'd2) begin bad++; $display("FAIL rd_ignored got=%h exp=2", rd_bin); end
        inc_v[1] = 1'b0;
    endtask

    task automatic test_mid_reset();
        rst_v[0] = 1'b1; tick(); rst_v[0] = 1'b0;
        rem_v[0] = 4'd0; inc_v[0] = 1'b1;
        repeat (5) tick();
        inc_v[0] = 1'b0; rem_v[0] = 4'b0010;
        tick(); tick();
        total += 2;
        if (wr_bin !== 4'd5) begin bad++; $display("FAIL mid_pre_bin got=%h exp=5", wr_bin); end
        if (dut_wr.rgray_s !== 4'b0010) begin bad++; $display("FAIL mid_pre_sync got=%b exp=0010", dut_wr.rgray_s); end
        rst_v[0] = 1'b1; inc_v[0] = 1'b1;
        tick();
        total += 5;
        if (wr_bin !== 4'd0) begin bad++; $display("FAIL mid_bin got=%h exp=0", wr_bin); end
        if (wr_gray !== 4'd0) begin bad++; $display("FAIL mid_gray got=%b exp=0000", wr_gray); end
        if (wr_level !== 4'd0) begin bad++; $display("FAIL mid_level got=%h exp=0", wr_level); end
        if (wr_flag !== 1'b0) begin bad++; $display("FAIL mid_flag got=%b exp=0", wr_flag); end
        if (dut_wr.rgray_s !== 4'd0) begin bad++; $display("FAIL mid_sync got=%b exp=0000", dut_wr.rgray_s); end
        rst_v[0] = 1'b0; inc_v[0] = 1'b0; rem_v[0] = 4'd0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            m_bin[s] = 4'd0; m_s0[s] = 4'd0; m_s1[s] = 4'd0; m_level[s] = 4'd0; m_flag[s] = 1'b0;
            rst_v[s] = 1'b1; inc_v[s] = 1'b0; rem_v[s] = 4'd0;
        end
        test_reset();
        test_fill();
        test_full_release();
        test_wrap();
        test_read_side();
        test_mid_reset();
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
